// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: registered execute results, wait-stated DMEM, LEDR/HEX MMIO
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef OP_LDW
`define OP_LDW 8'h50
`endif
`ifndef OP_STW
`define OP_STW 8'h51
`endif

module mem_stage #(
  parameter int DMEM_ADDR_W = 10,
  parameter int WAIT_STATES = 2,
  parameter logic [`REG_WIDTH-1:0] LEDR_ADDR = 16'hF000,
  parameter logic [`REG_WIDTH-1:0] HEX_ADDR  = 16'hF004
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET_N,
  input  logic                     I_LOCK,
  input  logic [`REG_WIDTH-1:0]    I_ALUOut,
  input  logic [`OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [3:0]               I_DestRegIdx,
  input  logic [`REG_WIDTH-1:0]    I_DestValue,
  input  logic                     I_FetchStall,
  input  logic                     I_DepStall,
  output logic                     O_LOCK,
  output logic [`REG_WIDTH-1:0]    O_ALUOut,
  output logic [`REG_WIDTH-1:0]    O_MemOut,
  output logic [`OPCODE_WIDTH-1:0] O_Opcode,
  output logic [3:0]               O_DestRegIdx,
  output logic                     O_FetchStall,
  output logic                     O_DepStall,
  output logic                     O_MemBusy,
  output logic [9:0]               O_LEDR,
  output logic [15:0]              O_HEX
);

  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           cnt;
  logic                       req_is_st;
  logic [DMEM_ADDR_W-1:0]     req_idx;
  logic [`REG_WIDTH-1:0]      req_addr;
  logic [`REG_WIDTH-1:0]      req_data;
  logic [`OPCODE_WIDTH-1:0]   req_op;
  logic [3:0]                 req_dest;

  logic [`REG_WIDTH-1:0]      dmem [0:(1<<DMEM_ADDR_W)-1];

  logic                       is_ldw, is_stw, valid_mem;
  logic                       hit_ledr, hit_hex, hit_mmio;
  logic [DMEM_ADDR_W-1:0]     in_idx, mem_idx;
  logic [`REG_WIDTH-1:0]      mem_wdata, mem_rdata;
  logic                       mem_we;
  logic                       start_wait, finish_wait, direct_dmem;

  assign is_ldw    = (I_Opcode == `OP_LDW);
  assign is_stw    = (I_Opcode == `OP_STW);
  assign valid_mem = I_LOCK && !I_FetchStall && !I_DepStall && (is_ldw || is_stw);
  assign hit_ledr  = (I_ALUOut == LEDR_ADDR);
  assign hit_hex   = (I_ALUOut == HEX_ADDR);
  assign hit_mmio  = hit_ledr || hit_hex;
  assign in_idx    = I_ALUOut[DMEM_ADDR_W+1:2];

  always_comb begin
    state_nxt   = state;
    start_wait  = 1'b0;
    finish_wait = 1'b0;
    direct_dmem = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_mem && !hit_mmio) begin
          if (WAIT_STATES == 0) begin
            direct_dmem = 1'b1;
          end else begin
            start_wait = 1'b1;
            state_nxt  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          finish_wait = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The single DMEM port serves either the live request or the latched one.
  assign mem_idx   = (state == S_WAIT) ? req_idx : in_idx;
  assign mem_wdata = (state == S_WAIT) ? req_data : I_DestValue;
  assign mem_we    = (direct_dmem && is_stw) || (finish_wait && req_is_st);
  assign mem_rdata = dmem[mem_idx];

  // DMEM has no reset; gating on I_RESET_N keeps an aborted access from landing.
  always_ff @(negedge I_CLOCK) begin
    if (mem_we && I_RESET_N)
      dmem[mem_idx] <= mem_wdata;
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state        <= S_IDLE;
      cnt          <= '0;
      req_is_st    <= 1'b0;
      req_idx      <= '0;
      req_addr     <= '0;
      req_data     <= '0;
      req_op       <= '0;
      req_dest     <= '0;
      O_LOCK       <= 1'b0;
      O_ALUOut     <= '0;
      O_MemOut     <= '0;
      O_Opcode     <= '0;
      O_DestRegIdx <= '0;
      O_FetchStall <= 1'b0;
      O_DepStall   <= 1'b0;
      O_MemBusy    <= 1'b0;
      O_LEDR       <= '0;
      O_HEX        <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
        O_LOCK       <= I_LOCK;
        O_FetchStall <= I_FetchStall;
        if (start_wait) begin
          req_is_st  <= is_stw;
          req_idx    <= in_idx;
          req_addr   <= I_ALUOut;
          req_data   <= I_DestValue;
          req_op     <= I_Opcode;
          req_dest   <= I_DestRegIdx;
          cnt        <= CNT_INIT;
          O_MemBusy  <= 1'b1;
          O_DepStall <= 1'b1;
        end else if (I_LOCK) begin
          O_ALUOut     <= I_ALUOut;
          O_Opcode     <= I_Opcode;
          O_DestRegIdx <= I_DestRegIdx;
          O_DepStall   <= I_DepStall;
          O_MemOut     <= '0;
          if (valid_mem && is_ldw) begin
            if (hit_ledr)
              O_MemOut <= `REG_WIDTH'(O_LEDR);
            else if (hit_hex)
              O_MemOut <= `REG_WIDTH'(O_HEX);
            else
              O_MemOut <= mem_rdata;
          end
          if (valid_mem && is_stw && hit_ledr)
            O_LEDR <= I_DestValue[9:0];
          if (valid_mem && is_stw && hit_hex)
            O_HEX <= I_DestValue[15:0];
        end
      end else if (!finish_wait) begin
        cnt        <= cnt - 1'b1;
        O_DepStall <= 1'b1;
      end else begin
        O_ALUOut     <= req_addr;
        O_Opcode     <= req_op;
        O_DestRegIdx <= req_dest;
        O_DepStall   <= 1'b0;
        O_MemBusy    <= 1'b0;
        O_MemOut     <= req_is_st ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized bench for mem_stage against a transaction-level reference model
module tb_mem_stage;

  localparam logic [7:0]  OP_LDW  = 8'h50;
  localparam logic [7:0]  OP_STW  = 8'h51;
  localparam logic [7:0]  OP_ADDI = 8'h20;
  localparam int          WS      = 2;
  localparam logic [15:0] LEDR_A  = 16'hF000;
  localparam logic [15:0] HEX_A   = 16'hF004;

  logic        clk = 1'b1;
  logic        rst_n;
  logic        i_lock, i_fs, i_ds;
  logic [15:0] i_alu, i_val;
  logic [7:0]  i_op;
  logic [3:0]  i_dest;
  logic        o_lock, o_fs, o_ds, o_busy;
  logic [15:0] o_alu, o_mem, o_hex;
  logic [7:0]  o_op;
  logic [3:0]  o_dest;
  logic [9:0]  o_ledr;

  int checks = 0;
  int failures = 0;

  logic [15:0] mdl [0:1023];
  logic        e_lock, e_fs, e_ds, e_busy;
  logic [15:0] e_alu, e_mem, e_hex;
  logic [7:0]  e_op;
  logic [3:0]  e_dest;
  logic [9:0]  e_ledr;

  always #5 clk = ~clk;

  mem_stage dut (
    .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(i_lock), .I_ALUOut(i_alu),
    .I_Opcode(i_op), .I_DestRegIdx(i_dest), .I_DestValue(i_val),
    .I_FetchStall(i_fs), .I_DepStall(i_ds),
    .O_LOCK(o_lock), .O_ALUOut(o_alu), .O_MemOut(o_mem), .O_Opcode(o_op),
    .O_DestRegIdx(o_dest), .O_FetchStall(o_fs), .O_DepStall(o_ds),
    .O_MemBusy(o_busy), .O_LEDR(o_ledr), .O_HEX(o_hex)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".lock"}, 32'(o_lock), 32'(e_lock));
    check({tag, ".alu"},  32'(o_alu),  32'(e_alu));
    check({tag, ".mem"},  32'(o_mem),  32'(e_mem));
    check({tag, ".op"},   32'(o_op),   32'(e_op));
    check({tag, ".dest"}, 32'(o_dest), 32'(e_dest));
    check({tag, ".fs"},   32'(o_fs),   32'(e_fs));
    check({tag, ".ds"},   32'(o_ds),   32'(e_ds));
    check({tag, ".busy"}, 32'(o_busy), 32'(e_busy));
    check({tag, ".ledr"}, 32'(o_ledr), 32'(e_ledr));
    check({tag, ".hex"},  32'(o_hex),  32'(e_hex));
  endtask

  task automatic clear_model();
    e_lock = 0; e_fs = 0; e_ds = 0; e_busy = 0;
    e_alu = 0; e_mem = 0; e_hex = 0; e_op = 0; e_dest = 0; e_ledr = 0;
  endtask

  task automatic scramble();
    i_alu  = 16'($urandom);
    i_op   = 8'($urandom);
    i_dest = 4'($urandom);
    i_val  = 16'($urandom);
    i_lock = 1'($urandom);
    i_fs   = 1'($urandom);
    i_ds   = 1'($urandom);
  endtask

  // One instruction from execute; the bench holds it (scrambled here) while busy.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [15:0] addr,
                        input logic [3:0] dest, input logic [15:0] val,
                        input logic lock, input logic fs, input logic ds);
    logic valid, mmio;
    int   idx;
    i_op = op; i_alu = addr; i_dest = dest; i_val = val;
    i_lock = lock; i_fs = fs; i_ds = ds;
    valid = lock && !fs && !ds && (op == OP_LDW || op == OP_STW);
    mmio  = (addr == LEDR_A) || (addr == HEX_A);
    idx   = int'(addr[11:2]);
    @(negedge clk); #1;
    e_lock = lock; e_fs = fs;
    if (valid && !mmio) begin
      e_busy = 1; e_ds = 1;
      check_all({tag, ".issue"});
      for (int k = 1; k < WS; k++) begin
        scramble();
        @(negedge clk); #1;
        check_all({tag, ".wait"});
      end
      scramble();
      @(negedge clk); #1;
      e_busy = 0; e_ds = 0;
      e_alu = addr; e_op = op; e_dest = dest;
      if (op == OP_STW) begin
        mdl[idx] = val;
        e_mem = 0;
      end else begin
        e_mem = mdl[idx];
      end
      check_all({tag, ".done"});
    end else begin
      if (lock) begin
        e_alu = addr; e_op = op; e_dest = dest; e_ds = ds; e_mem = 0;
        if (valid && op == OP_LDW)
          e_mem = (addr == LEDR_A) ? {6'd0, e_ledr} : (addr == HEX_A) ? e_hex : mdl[idx];
        if (valid && op == OP_STW && addr == LEDR_A) e_ledr = val[9:0];
        if (valid && op == OP_STW && addr == HEX_A)  e_hex = val;
      end
      check_all({tag, ".op"});
    end
  endtask

  initial begin
    clear_model();
    rst_n = 0;
    i_lock = 0; i_fs = 0; i_ds = 0; i_alu = 0; i_op = 0; i_dest = 0; i_val = 0;
    #12;
    check_all("reset");
    @(posedge clk); rst_n = 1;

    for (int i = 0; i < 16; i++)
      run_op("preload", OP_STW, 16'(i * 4), 4'(i), 16'($urandom), 1, 0, 0);

    // reset during the wait window must abort the store
    i_op = OP_STW; i_alu = 16'h0010; i_val = 16'h1234; i_dest = 4'h3;
    i_lock = 1; i_fs = 0; i_ds = 0;
    @(negedge clk); #1;
    check("midwait.busy", 32'(o_busy), 32'd1);
    #2 rst_n = 0;
    #1 clear_model();
    check_all("midwait.reset");
    @(posedge clk); rst_n = 1;
    run_op("midwait.ld", OP_LDW, 16'h0010, 4'h3, 16'h0, 1, 0, 0);

    run_op("addi",    OP_ADDI, 16'h0042, 4'h1, 16'h0, 1, 0, 0);
    run_op("st_beef", OP_STW,  16'h0020, 4'h2, 16'hBEEF, 1, 0, 0);
    run_op("ld_beef", OP_LDW,  16'h0020, 4'h2, 16'h0, 1, 0, 0);
    check("ld_beef.data", 32'(o_mem), 32'h0000BEEF);
    run_op("st_ledr", OP_STW,  LEDR_A, 4'h0, 16'h03FF, 1, 0, 0);
    run_op("st_hex",  OP_STW,  HEX_A,  4'h0, 16'hA5A5, 1, 0, 0);
    check("hex.val",  32'(o_hex), 32'h0000A5A5);
    run_op("ld_ledr", OP_LDW,  LEDR_A, 4'h5, 16'h0, 1, 0, 0);
    check("ld_ledr.data", 32'(o_mem), 32'h000003FF);
    run_op("ld_dep",  OP_LDW,  16'h0020, 4'h6, 16'h0, 1, 0, 1);
    run_op("st_alias", OP_STW, 16'h1004, 4'h7, 16'h5555, 1, 0, 0);
    run_op("ld_alias", OP_LDW, 16'h0004, 4'h7, 16'h0, 1, 0, 0);
    check("alias.data", 32'(o_mem), 32'h00005555);
    run_op("nolock",  OP_STW,  LEDR_A, 4'h8, 16'h0001, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [7:0]  op;
      logic [15:0] addr;
      int sel;
      sel = int'($urandom_range(0, 9));
      op  = (sel < 4) ? OP_LDW : (sel < 8) ? OP_STW : (sel == 8) ? OP_ADDI : 8'($urandom);
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      addr = LEDR_A;
      else if (sel == 1) addr = HEX_A;
      else               addr = {4'($urandom_range(0, 7)), 6'd0, 4'($urandom), 2'($urandom)};
      run_op("rand", op, addr, 4'($urandom), 16'($urandom),
             ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Pipeline memory stage, directly downstream of the execute stage and upstream of writeback. Registers execute results, performs LDW/STW against an internal word-addressed data memory with configurable wait states, and decodes two memory-mapped output registers (LEDR, HEX). Asserts a registered busy signal so the execute stage holds while a multi-cycle access is in flight.

Parameters:
DMEM_ADDR_W, 10, data memory index width (2^10 words of `REG_WIDTH bits)
WAIT_STATES, 2, extra falling edges per DMEM access (0 = single-edge access)
LEDR_ADDR, 16'hF000, byte address of LEDR register
HEX_ADDR, 16'hF004, byte address of HEX register

Ports:
I_CLOCK  in  1  pipeline clock; all state updates on falling edge
I_RESET_N  in  1  asynchronous active-low reset
I_LOCK  in  1  pipeline lock from execute
I_ALUOut  in  `REG_WIDTH  ALU result / effective byte address
I_Opcode  in  `OPCODE_WIDTH  opcode
I_DestRegIdx  in  4  destination register index
I_DestValue  in  `REG_WIDTH  store data for STW
I_FetchStall  in  1  upstream fetch bubble
I_DepStall  in  1  upstream dependency bubble
O_LOCK  out  1  registered I_LOCK
O_ALUOut  out  `REG_WIDTH  registered ALU result
O_MemOut  out  `REG_WIDTH  load data
O_Opcode  out  `OPCODE_WIDTH  registered opcode
O_DestRegIdx  out  4  registered destination index
O_FetchStall  out  1  registered fetch bubble
O_DepStall  out  1  bubble flag to writeback
O_MemBusy  out  1  backpressure to execute; execute holds outputs while high
O_LEDR  out  10  LEDR register
O_HEX  out  16  HEX register

Behaviour:
- One clock I_CLOCK; reset asynchronous, active-low (I_RESET_N). All registers update on negedge I_CLOCK or negedge I_RESET_N.
- Reset: every output 0, state IDLE, wait counter 0, latched request cleared. DMEM contents not cleared. Reset mid-WAIT aborts the access; no DMEM write occurs.
- "Valid mem op": I_LOCK=1, I_FetchStall=0, I_DepStall=0, opcode `OP_LDW or `OP_STW.
- DMEM index = I_ALUOut[DMEM_ADDR_W+1:2]; low two bits and upper bits ignored (aliasing). MMIO match is full-width equality on LEDR_ADDR/HEX_ADDR and takes priority over DMEM.
- O_LOCK <= I_LOCK and O_FetchStall <= I_FetchStall every edge outside WAIT; when I_LOCK=0 all other outputs hold.
- States: IDLE, WAIT.
- IDLE, non-mem op or bubble: O_ALUOut/O_Opcode/O_DestRegIdx/O_DepStall <= inputs; O_MemOut <= 0. Latency 1 edge.
- IDLE, valid mem op to MMIO: completes same edge. STW LEDR: O_LEDR <= I_DestValue[9:0]; STW HEX: O_HEX <= I_DestValue[15:0]; LDW returns zero-extended register in O_MemOut. No busy.
- IDLE, valid mem op to DMEM, WAIT_STATES=0: read/write DMEM same edge; LDW data in O_MemOut.
- IDLE, valid mem op to DMEM, WAIT_STATES>0: latch opcode, address, data, dest idx; counter <= WAIT_STATES-1; O_MemBusy <= 1; O_DepStall <= 1 (bubble out); go WAIT.
- WAIT, counter>0: decrement; O_DepStall <= 1; ignore inputs (execute holds next instruction there).
- WAIT, counter=0: perform DMEM read/write with latched request; emit latched opcode/idx/address with O_DepStall <= 0; O_MemBusy <= 0; go IDLE. Held input consumed on next edge.
- Total DMEM access latency = WAIT_STATES+1 falling edges; busy high for WAIT_STATES edges.
- I_LOCK dropping during WAIT does not abort the access.
- Back-to-back STW then LDW same address: LDW returns stored value.
- Arithmetic: none beyond index slicing; all data paths `REG_WIDTH, no sign extension on loads.

Test Plan:
- Reset asserted mid-WAIT of STW 16'h1234 @ 16'h0010 -> outputs 0, state IDLE; subsequent LDW @ 16'h0010 returns old (pre-store) value.
- ADDI passthrough, ALUOut 16'h0042, WAIT_STATES=2 -> O_ALUOut=16'h0042 after 1 edge, O_MemBusy never high.
- STW 16'hBEEF @ 16'h0020 then LDW @ 16'h0020 -> busy high 2 edges each, O_MemOut=16'hBEEF on 3rd edge of load, DepStall bubbles in between.
- STW 16'h03FF @ LEDR_ADDR; STW 16'hA5A5 @ HEX_ADDR -> O_LEDR=10'h3FF, O_HEX=16'hA5A5 after 1 edge each, no busy; LDW LEDR_ADDR -> O_MemOut=16'h03FF.
- LDW with I_DepStall=1 -> no access, no busy, O_DepStall=1 forwarded.
- Aliasing: STW 16'h5555 @ 16'h1004 (DMEM_ADDR_W=10) then LDW @ 16'h0004 -> 16'h5555.
